bus_device_port: RTL

Device-side endpoint for the bus generator/arbiter: one instance per device slot. It owns the device's TX queue and RX queue. The TX queue presents pndng/D_pop to the bus, which consumes entries with pop. The RX queue accepts D_push/push from the bus, filters by destination ID, and buffers packets for the local host. This is the counterpart the arbiter talks to on both its pop side and its push side.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_device_port_if.sv | 28 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/bus_device_port.sv | 108 ++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus device port: ID widths, broadcast address,
// packet field helpers and error flag bit positions.
package bus_pkg;

  localparam int ID_W      = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int PKT_W_MAX = 64;

  localparam int ERR_W       = 4;
  localparam int ERR_TX_OVF  = 0;
  localparam int ERR_POP_UDF = 1;
  localparam int ERR_RX_OVF  = 2;
  localparam int ERR_MISADDR = 3;

  // Callers zero-extend their packet to PKT_W_MAX and pass its real width.
  function automatic logic [ID_W-1:0] get_dst(input logic [PKT_W_MAX-1:0] pkt,
                                              input int pkt_w);
    logic [PKT_W_MAX-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

  function automatic logic [PKT_W_MAX-1:0] get_payload(input logic [PKT_W_MAX-1:0] pkt,
                                                       input int pkt_w);
    logic [PKT_W_MAX-1:0] mask;
    mask = (PKT_W_MAX'(1) << (pkt_w - ID_W)) - PKT_W_MAX'(1);
    return pkt & mask;
  endfunction

endpackage

// File: rtl/bus_device_port_if.sv
// Bus-side handshake between the arbiter (master) and one device port (slave).
interface bus_device_port_if #(
  parameter int PCKG_SZ = 24
);

  logic               pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [PCKG_SZ-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and one-bit-extended
// pointers; a write while full is accepted only when a read frees the slot.
module sync_fifo
  import bus_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         udf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         empty_s;
  logic         full_s;
  logic         do_rd_s;
  logic         do_wr_s;

  // Status and accepted-operation decode from the registered pointers.
  always_comb begin
    empty_s = (wptr_r == rptr_r);
    full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    do_rd_s = rd && !empty_s;
    do_wr_s = wr && (!full_s || do_rd_s);
    if (empty_s) begin
      dout = {W{1'b0}};
    end else begin
      dout = mem_r[rptr_r[AW-1:0]];
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign ovf   = wr && full_s && !do_rd_s;
  assign udf   = rd && empty_s;

  // Pointer registers; contents are discarded by resetting the pointers only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array, written on accepted enqueues.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/bus_device_port.sv
// Device endpoint on the arbitrated bus: TX queue toward the bus, address-
// filtered RX queue toward the host, sticky error flags and a drop counter.
module bus_device_port
  import bus_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter int              PCKG_SZ  = WIDTH + 8,
  parameter logic [ID_W-1:0] ID       = 8'd0,
  parameter logic [ID_W-1:0] BCAST    = BCAST_ID,
  parameter int              TX_DEPTH = 8,
  parameter int              RX_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [ID_W-1:0]    tx_dst,
  input  logic [WIDTH-1:0]   tx_data,
  output logic               tx_full,
  bus_device_port_if.slave   bus,
  input  logic               rx_rd,
  output logic               rx_valid,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic [ERR_W-1:0]   err_flags,
  output logic [7:0]         drop_cnt
);

  logic [PCKG_SZ-1:0] tx_pkt_s;
  logic [PCKG_SZ-1:0] tx_dout_s;
  logic               tx_empty_s;
  logic               tx_ovf_s;
  logic               tx_udf_s;
  logic [ID_W-1:0]    rx_dst_s;
  logic               addr_ok_s;
  logic               rx_wr_s;
  logic               misaddr_s;
  logic               rx_empty_s;
  logic               rx_full_s;
  logic               rx_ovf_s;
  logic               rx_udf_unused_s;
  logic               drop_s;
  logic [ERR_W-1:0]   err_set_s;
  logic [ERR_W-1:0]   err_flags_r;
  logic [7:0]         drop_cnt_r;

  assign tx_pkt_s = PCKG_SZ'({tx_dst, tx_data});

  sync_fifo #(.W(PCKG_SZ), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .din   (tx_pkt_s),
    .rd    (bus.pop),
    .dout  (tx_dout_s),
    .full  (tx_full),
    .empty (tx_empty_s),
    .ovf   (tx_ovf_s),
    .udf   (tx_udf_s)
  );

  assign bus.pndng = !tx_empty_s;
  assign bus.D_pop = tx_dout_s;

  // Destination filter and per-cycle error/drop events.
  always_comb begin
    rx_dst_s  = get_dst(PKT_W_MAX'(bus.D_push), PCKG_SZ);
    addr_ok_s = (rx_dst_s == ID) || (rx_dst_s == BCAST);
    rx_wr_s   = bus.push && addr_ok_s;
    misaddr_s = bus.push && !addr_ok_s;
    drop_s    = misaddr_s || rx_ovf_s;
    err_set_s = {ERR_W{1'b0}};
    err_set_s[ERR_TX_OVF]  = tx_ovf_s;
    err_set_s[ERR_POP_UDF] = tx_udf_s;
    err_set_s[ERR_RX_OVF]  = rx_ovf_s;
    err_set_s[ERR_MISADDR] = misaddr_s;
  end

  sync_fifo #(.W(PCKG_SZ), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr_s),
    .din   (bus.D_push),
    .rd    (rx_rd),
    .dout  (rx_data),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .ovf   (rx_ovf_s),
    .udf   (rx_udf_unused_s)
  );

  assign rx_valid = !rx_empty_s;

  // Sticky error flags and saturating drop counter; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flags_r <= {ERR_W{1'b0}};
      drop_cnt_r  <= 8'd0;
    end else begin
      err_flags_r <= err_flags_r | err_set_s;
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  assign err_flags = err_flags_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
